irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// Register bus between the address-decode bridge and irq_ctrl: word address,
// pre-gated write strobe, write data and combinational read data.
interface irq_ctrl_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input  Dout);
    modport slave  (input  Addr, input  WE, input  Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// Six-source interrupt controller: MASK/PEND(W1C)/MODE/STATUS registers, edge or
// level capture per source. Define IRQ_CTRL_SYNC_EN to synchronise irq_in[2].
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    irq_ctrl_if.slave   bus,
    input  logic [5:0]  irq_in,
    output logic [5:0]  HWInt
);

    typedef enum logic [1:0] {
        REG_MASK   = 2'd0,
        REG_PEND   = 2'd1,
        REG_MODE   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    reg_sel_e   sel;
    logic [5:0] src;
    logic [5:0] set_vec, clr_vec, active;
    logic [2:0] status_idx;

    logic [5:0] mask_q,  mask_d;
    logic [5:0] pend_q,  pend_d;
    logic [5:0] mode_q,  mode_d;
    logic [5:0] prev_q,  prev_d;
    logic [5:0] hwint_q, hwint_d;

    assign sel = reg_sel_e'(bus.Addr[3:2]);

`ifdef IRQ_CTRL_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_in[2];
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign src = {irq_in[5:3], sync2_q, irq_in[1:0]};
`else
    assign src = irq_in;
`endif

    // MODE resets to level, so a source already high at reset release can
    // never be taken as an edge: prev has caught up before edge mode applies.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        set_vec = '0;
        clr_vec = '0;
        mask_d  = mask_q;
        mode_d  = mode_q;
        prev_d  = src;

        for (int i = 0; i < 6; i++)
            set_vec[i] = mode_q[i] ? (src[i] & ~prev_q[i]) : src[i];

        if (bus.WE) begin
            case (sel)
                REG_MASK: mask_d  = bus.Din[5:0];
                REG_PEND: clr_vec = bus.Din[5:0];
                REG_MODE: mode_d  = bus.Din[5:0];
                default:  ;
            endcase
        end

        // Set wins over a same-cycle write-1-to-clear.
        pend_d  = (pend_q & ~clr_vec) | set_vec;
        hwint_d = pend_d & mask_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            pend_q  <= '0;
            mode_q  <= '0;
            prev_q  <= '0;
            hwint_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            prev_q  <= prev_d;
            hwint_q <= hwint_d;
        end
    end

    assign HWInt  = hwint_q;
    assign active = pend_q & mask_q;

    // Scan downwards so the lowest active index is the last one written.
    always_comb begin
        status_idx = 3'd0;
        for (int i = 5; i >= 0; i--)
            if (active[i]) status_idx = 3'(i);
    end

    always_comb begin
        bus.Dout = '0;
        case (sel)
            REG_MASK:   bus.Dout[5:0] = mask_q;
            REG_PEND:   bus.Dout[5:0] = pend_q;
            REG_MODE:   bus.Dout[5:0] = mode_q;
            REG_STATUS: begin
                bus.Dout[31]  = |active;
                bus.Dout[2:0] = status_idx;
            end
            default:    bus.Dout = '0;
        endcase
    end

endmodule
